// File: rtl/uart_rx_uint32_hex.sv
// ASCII hex number parser downstream of the UART byte receiver: accumulates up to
// MAX_DIGITS hex digits per field and presents each completed number on a valid/ack register.
module uart_rx_uint32_hex #(
  parameter int MAX_DIGITS = 8,
  parameter int TIMEOUT    = 160
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        baud_x4,
  input  logic [7:0]  data,
  input  logic        data_strobe,
  output logic [31:0] value,
  output logic [3:0]  digit_count,
  output logic        value_valid,
  input  logic        value_ack,
  output logic        error,
  output logic        overrun
);

  localparam int              TW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      MAXD = 4'(MAX_DIGITS);
  localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD} state_t;

  state_t         state_q, state_d;
  logic [31:0]    acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [TW-1:0]  sil_q, sil_d;
  logic [31:0]    value_q, value_d;
  logic [3:0]     dcnt_q, dcnt_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           ovr_q, ovr_d;

  logic           is_num, is_alpha, is_dig, is_term, complete;
  logic [3:0]     nib;

  // Character classification; letters map to 10..15 via low nibble + 9.
  always_comb begin
    is_num   = (data >= 8'h30) && (data <= 8'h39);
    is_alpha = ((data >= 8'h41) && (data <= 8'h46)) ||
               ((data >= 8'h61) && (data <= 8'h66));
    is_dig   = is_num || is_alpha;
    nib      = data[3:0] + (is_alpha ? 4'd9 : 4'd0);
    is_term  = (data == 8'h0D) || (data == 8'h0A) ||
               (data == 8'h20) || (data == 8'h2C);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sil_d    = sil_q;
    value_d  = value_q;
    dcnt_d   = dcnt_q;
    valid_d  = valid_q;
    err_d    = 1'b0;
    ovr_d    = 1'b0;
    complete = 1'b0;

    if (valid_q && value_ack) valid_d = 1'b0;
    if (state_q == S_IDLE) sil_d = '0;

    if (data_strobe) begin
      sil_d = '0;
      case (state_q)
        S_IDLE: begin
          if (is_dig) begin
            acc_d   = {28'd0, nib};
            cnt_d   = 4'd1;
            state_d = S_ACCUM;
          end else if (!is_term) begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_ACCUM: begin
          if (is_dig && (cnt_q < MAXD)) begin
            acc_d = {acc_q[27:0], nib};
            cnt_d = cnt_q + 4'd1;
          end else begin
            acc_d = '0;
            cnt_d = '0;
            if (is_term) begin
              complete = 1'b1;
              state_d  = S_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = S_DISCARD;
            end
          end
        end
        S_DISCARD: begin
          if (is_term) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (baud_x4 && (state_q != S_IDLE)) begin
      // Strobe-free tick: line silence; abandon the field once TIMEOUT is reached.
      if (sil_q + 1'b1 == TLIM) begin
        state_d = S_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        sil_d   = '0;
        err_d   = (state_q == S_ACCUM);
      end else begin
        sil_d = sil_q + 1'b1;
      end
    end

    // A same-cycle ack frees the holding register for the new number.
    if (complete) begin
      if (!valid_q || value_ack) begin
        value_d = acc_q;
        dcnt_d  = cnt_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sil_q   <= '0;
      value_q <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sil_q   <= sil_d;
      value_q <= value_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign value       = value_q;
  assign digit_count = dcnt_q;
  assign value_valid = valid_q;
  assign error       = err_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_uint32_hex.sv
// Scoreboard bench: stimulus pushes expected events (value/error/overrun), a negedge
// monitor pops and compares whenever the parser presents one.
module tb_uart_rx_uint32_hex;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        baud_x4 = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        data_strobe = 1'b0;
  logic [31:0] value;
  logic [3:0]  digit_count;
  logic        value_valid;
  logic        value_ack = 1'b0;
  logic        error;
  logic        overrun;

  uart_rx_uint32_hex dut (
    .mclk(mclk), .reset(reset), .baud_x4(baud_x4), .data(data),
    .data_strobe(data_strobe), .value(value), .digit_count(digit_count),
    .value_valid(value_valid), .value_ack(value_ack), .error(error), .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int          kind;  // 0 value load, 1 error, 2 overrun
    logic [31:0] val;
    logic [3:0]  cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] val, input logic [3:0] cnt);
    ev_t e;
    e.kind = kind; e.val = val; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    data = b;
    data_strobe = 1'b1;
    @(posedge mclk); #1;
    data_strobe = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge mclk); #1; end
  endtask

  task automatic ack();
    value_ack = 1'b1;
    @(posedge mclk); #1;
    value_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      baud_x4 = 1'b1;
      @(posedge mclk); #1;
      baud_x4 = 1'b0;
      @(posedge mclk); #1;
    end
  endtask

  // Monitor: a load is a rising value_valid or a changed value while valid stays high.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_value = '0;
  logic [3:0]  prev_cnt = '0;

  task automatic pop_cmp(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind == 0 && e.kind == 0) begin
        check("value", value, e.val);
        check("digit_count", 32'(digit_count), 32'(e.cnt));
      end
    end
  endtask

  always @(negedge mclk) begin
    if (!reset) begin
      if (error) pop_cmp(1);
      if (overrun) pop_cmp(2);
      if (value_valid && (!prev_valid || value != prev_value || digit_count != prev_cnt))
        pop_cmp(0);
    end
    prev_valid = value_valid;
    prev_value = value;
    prev_cnt   = digit_count;
  end

  initial begin
    idle(3);
    check("reset_value", value, 32'h0);
    check("reset_count", 32'(digit_count), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_err_ovr", {30'd0, error, overrun}, 32'h0);
    @(posedge mclk); #1;
    reset = 1'b0;
    idle(2);

    // Basic number, CR/LF pair, handshake
    push(0, 32'h0000_1A2B, 4'd4);
    send_str("1A2b");
    check("valid_before_cr", 32'(value_valid), 32'h0);
    send_byte(8'h0D);
    check("valid_after_cr", 32'(value_valid), 32'h1);
    send_byte(8'h0A);
    idle(2);
    ack();
    check("valid_after_ack", 32'(value_valid), 32'h0);

    // Eight digits, too many digits, comma terminator
    push(0, 32'hDEAD_BEEF, 4'd8);
    send_str("DEADBEEF\n");
    ack();
    push(1, 0, 0);
    send_str("123456789\n");
    idle(2);
    check("no_value_after_9_digits", 32'(value_valid), 32'h0);
    push(0, 32'h0000_0007, 4'd1);
    send_str("7,");
    ack();

    // Bad character discards rest of the field
    push(1, 0, 0);
    send_str("12G4\n");
    push(0, 32'h0000_0005, 4'd1);
    send_str("5 ");
    ack();

    // Overrun, then load with same-cycle ack
    push(0, 32'h0000_0001, 4'd1);
    send_str("1\n");
    push(2, 0, 0);
    send_str("2\n");
    idle(1);
    check("held_after_overrun", value, 32'h0000_0001);
    push(0, 32'h0000_0003, 4'd1);
    send_str("3");
    value_ack = 1'b1;
    send_byte(8'h0A);
    value_ack = 1'b0;
    check("value_after_ack_load", value, 32'h0000_0003);
    check("valid_after_ack_load", 32'(value_valid), 32'h1);
    ack();

    // Timeout in ACCUM: error, partial number abandoned
    send_str("AB");
    ticks(159);
    check("no_timeout_at_159", 32'(exp_q.size()), 32'h0);
    push(1, 0, 0);
    ticks(1);
    push(0, 32'h0000_000C, 4'd1);
    send_str("C\n");
    ack();

    // Strobe on the 160th tick cancels the timeout
    send_str("AB");
    ticks(159);
    baud_x4 = 1'b1;
    send_byte("C");
    baud_x4 = 1'b0;
    push(0, 32'h0000_0ABC, 4'd3);
    send_str("\n");
    ack();

    // Timeout in DISCARD: silent return to IDLE
    push(1, 0, 0);
    send_str("G");
    ticks(160);
    push(0, 32'h0000_0009, 4'd1);
    send_str("9\n");
    ack();

    // Asynchronous reset mid-number with a value held
    push(0, 32'h0000_0001, 4'd1);
    send_str("1\n12");
    #2 reset = 1'b1;
    #1;
    check("async_reset_value", value, 32'h0);
    check("async_reset_valid", 32'(value_valid), 32'h0);
    check("async_reset_count", 32'(digit_count), 32'h0);
    @(posedge mclk); #1;
    reset = 1'b0;
    push(0, 32'h0000_0003, 4'd1);
    send_str("3\n");
    check("value_after_reset", value, 32'h0000_0003);
    idle(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_uint32_hex.md
# uart_rx_uint32_hex

Parses ASCII hexadecimal numbers from the received UART byte stream into 32-bit unsigned values. It sits downstream of the byte receiver, consuming its `data`/`data_strobe` pair, and is the inbound counterpart of the 32-bit value transmitter. It presents each completed number on a valid/ack holding register with digit count, error and overrun reporting, and discards stale partial numbers after an inter-character timeout.

## Interface
- `MAX_DIGITS`, default 8: maximum hex digits per number (1..8).
- `TIMEOUT`, default 160: `baud_x4` ticks of line silence (≈40 bit times) that abandon a partial number; nonzero.
- `mclk` in 1: master clock.
- `reset` in 1: asynchronous, active-high reset.
- `baud_x4` in 1: one-`mclk` tick at 4× baud rate; timebase for the timeout.
- `data` in 8: received byte; valid while `data_strobe` is high.
- `data_strobe` in 1: one-cycle pulse per received byte; each high cycle is one byte.
- `value` out 32: latched number, right-aligned and zero-extended.
- `digit_count` out 4: number of digits in `value` (1..`MAX_DIGITS`).
- `value_valid` out 1: `value`/`digit_count` hold an unconsumed number.
- `value_ack` in 1: consumer takes the number; effective only while `value_valid`.
- `error` out 1: one-cycle pulse on a malformed number.
- `overrun` out 1: one-cycle pulse when a completed number is dropped because the holding register is full.

## Operation
- Character classes:
  - digit: `0`-`9`, `A`-`F`, `a`-`f`, mapped to a nibble.
  - terminator: CR 0x0D, LF 0x0A, space 0x20, comma 0x2C.
  - other: all remaining bytes.
- Parser state: 2-bit FSM (IDLE, ACCUM, DISCARD), 32-bit accumulator `acc`, 4-bit counter `cnt`.
- IDLE:
  - digit → `acc` = nibble, `cnt` = 1, go to ACCUM.
  - terminator → ignored, so CR LF, repeated spaces and other empty fields produce nothing.
  - other → `error` pulse, go to DISCARD.
- ACCUM:
  - digit with `cnt` < `MAX_DIGITS` → `acc` = {`acc[27:0]`, nibble}, `cnt`+1.
  - digit with `cnt` = `MAX_DIGITS` → `error` pulse, go to DISCARD.
  - terminator → complete the number (see below), then go to IDLE.
  - other → `error` pulse, go to DISCARD.
- DISCARD:
  - terminator → go to IDLE.
  - all other bytes → ignored, no further `error` pulses.
- Leaving ACCUM for any reason clears `acc` and `cnt`.
- Completing a number:
  - `value_valid`=0, or `value_ack`=1 in the same cycle: load `value`=`acc` and `digit_count`=`cnt`; `value_valid`=1.
  - Otherwise: `overrun` pulse; the new number is dropped and the held `value` is unchanged.
- Handshake: `value_valid` && `value_ack` with no simultaneous load → `value_valid` 0 next cycle. `value_ack` while `value_valid`=0 has no effect.
- Timeout:
  - The silence counter clears on every `data_strobe` and in IDLE.
  - In ACCUM or DISCARD it increments on each `baud_x4` tick that has no simultaneous `data_strobe`.
  - Reaching `TIMEOUT` → go to IDLE and clear `acc`/`cnt`. Emit an `error` pulse only if the timeout occurred in ACCUM.
  - A simultaneous `data_strobe` takes priority over the timeout.
- Reset (asynchronous, any time, including mid-number): FSM to IDLE; `acc`, `cnt`, silence counter, `value`, `digit_count`, `value_valid`, `error`, `overrun` all 0.

## Timing
- All outputs are registered.
- `value_valid` rises one `mclk` after the terminator's `data_strobe` cycle.
- `error` and `overrun` are high exactly one `mclk`, the cycle after the causing strobe or timeout tick.
- Throughput: one byte per `mclk` is accepted; no minimum spacing between `data_strobe` pulses.
- A timeout fires on the `baud_x4` tick that brings the counter to `TIMEOUT`. Its effects are visible the next cycle.

## Test plan
- "1A2b\r\n" → `value`=0x00001A2B, `digit_count`=4, `value_valid` one cycle after the CR strobe. LF produces nothing. Ack → `value_valid` low next cycle.
- "DEADBEEF\n" → 0xDEADBEEF, count 8. Then "123456789\n" → `error` on the 9th digit and no value. Then "7," → 0x00000007, count 1.
- "12G4\n" → single `error` pulse at 'G' and no value. Then "5 " → 0x00000005.
- "1\n" with no ack, then "2\n" → `overrun` pulse, `value` stays 0x1. Then "3\n" with `value_ack` asserted in the LF strobe cycle → `value`=0x3, `value_valid` stays high, no `overrun`.
- "AB", then 160 `baud_x4` ticks of silence → `error` pulse and return to IDLE. Then "C\n" → 0x0000000C, not 0xABC. A strobe landing on the 160th tick cancels the timeout.
- Assert `reset` asynchronously after "12" with `value_valid` high → all outputs 0 immediately. After release, "3\n" → 0x00000003, count 1.
